// File: rtl/tone_synth.sv
// Square-wave tone generator: a phase accumulator advances once per sample
// tick. The sign of the output follows the accumulator MSB. Pitch changes are
// taken only at phase wrap. Samples leave through a valid/ready handshake, and
// a sticky flag records any sample dropped under backpressure.
module tone_synth #(
    parameter int width_p     = 32,
    parameter int div_p       = 1024,
    parameter int amp_width_p = 12,
    parameter int amp_p       = 1000
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic [width_p-1:0]     fstep_i,
    input  logic                   ready_i,
    output logic [amp_width_p-1:0] sample_o,
    output logic                   valid_o,
    output logic                   active_o,
    output logic                   overrun_o
);

    localparam int cnt_w = (div_p > 1) ? $clog2(div_p) : 1;
    localparam logic [amp_width_p-1:0] amp_pos = amp_width_p'(amp_p);
    localparam logic [amp_width_p-1:0] amp_neg = amp_width_p'(-amp_p);

    typedef enum logic {
        SILENT = 1'b0,
        PLAY   = 1'b1
    } state_t;

    logic [cnt_w-1:0]       div_cnt;
    logic                   tick;
    state_t                 state, state_nxt;
    logic [width_p-1:0]     phase, phase_nxt;
    logic [width_p-1:0]     step_active, step_nxt;
    logic [width_p:0]       sum;
    logic [amp_width_p-1:0] sample_nxt;

    assign tick     = (div_cnt == cnt_w'(div_p - 1));
    assign active_o = (state == PLAY);

    // Free-running sample-rate divider, independent of state and handshake.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        // NOTE: registers are written with <= so every flop samples pre-edge values.
        if (!reset_ni)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + cnt_w'(1);
    end

    // Next phase, step, state and candidate sample for the coming tick.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_nxt  = state;
        phase_nxt  = phase;
        step_nxt   = step_active;
        sample_nxt = '0;
        sum        = {1'b0, phase} + {1'b0, step_active};
        case (state)
            SILENT: begin
                if (fstep_i != '0) begin
                    step_nxt   = fstep_i;
                    phase_nxt  = fstep_i;
                    state_nxt  = PLAY;
                    sample_nxt = fstep_i[width_p-1] ? amp_neg : amp_pos;
                end else begin
                    phase_nxt = '0;
                end
            end
            PLAY: begin
                if (!sum[width_p]) begin
                    // Mid-cycle: keep the current pitch, ignore fstep_i.
                    phase_nxt  = sum[width_p-1:0];
                    sample_nxt = sum[width_p-1] ? amp_neg : amp_pos;
                end else if (fstep_i != '0) begin
                    // Wrap: a new step is loaded and used from the next tick.
                    phase_nxt  = sum[width_p-1:0];
                    step_nxt   = fstep_i;
                    sample_nxt = sum[width_p-1] ? amp_neg : amp_pos;
                end else begin
                    // Wrap with a zero step: the note ends cleanly.
                    phase_nxt = '0;
                    state_nxt = SILENT;
                end
            end
            default: state_nxt = SILENT;
        endcase
    end

    // Oscillator state advances on every tick, even while output is stalled.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= SILENT;
            phase       <= '0;
            step_active <= '0;
        end else if (tick) begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            step_active <= step_nxt;
        end
    end

    // Output handshake: load on tick when the slot is free, otherwise drop and flag.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sample_o  <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else if (tick) begin
            if (!valid_o || ready_i) begin
                sample_o <= sample_nxt;
                valid_o  <= 1'b1;
            end else begin
                overrun_o <= 1'b1;
            end
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth (width 8, divide 4, amplitude 100).
// Expected samples are queued as stimulus is applied and popped as the
// DUT hands samples out.
module tb_tone_synth;

    localparam int          W   = 8;
    localparam int          DIV = 4;
    localparam logic [11:0] POS = 12'h064;   // +100
    localparam logic [11:0] NEG = 12'hF9C;   // -100

    typedef struct {
        logic [11:0] smp;
        logic        act;
    } exp_t;

    logic          clk_i    = 1'b0;
    logic          reset_ni = 1'b0;
    logic [W-1:0]  fstep_i  = '0;
    logic          ready_i  = 1'b1;
    logic [11:0]   sample_o;
    logic          valid_o;
    logic          active_o;
    logic          overrun_o;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rel_cyc  = 0;
    int   last_cyc = 0;

    tone_synth #(
        .width_p    (W),
        .div_p      (DIV),
        .amp_width_p(12),
        .amp_p      (100)
    ) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .fstep_i  (fstep_i),
        .ready_i  (ready_i),
        .sample_o (sample_o),
        .valid_o  (valid_o),
        .active_o (active_o),
        .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [11:0] smp, input logic act);
        exp_t e;
        e.smp = smp;
        e.act = act;
        sb.push_back(e);
    endtask

    // Wait (bounded) for a sample to be handed out, compare it against the
    // head of the scoreboard, then step past the consuming edge.
    task automatic get_sample(input string tag);
        exp_t e;
        bit   found = 0;
        for (int i = 0; i < 5 * DIV; i++) begin
            if (valid_o && ready_i) begin
                found = 1;
                break;
            end
            @(negedge clk_i);
        end
        if (!found) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            check({tag, "_unexpected"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            last_cyc = cyc - rel_cyc;
            check({tag, "_sample"}, 32'(sample_o), 32'(e.smp));
            check({tag, "_active"}, 32'(active_o), 32'(e.act));
        end
        @(negedge clk_i);
    endtask

    initial begin
        // Reset state, with reset held from time zero.
        #12;
        check("rst_sample",  32'(sample_o),  32'd0);
        check("rst_valid",   32'(valid_o),   32'd0);
        check("rst_active",  32'(active_o),  32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);

        // Silence: pulses on cycles 4, 8, 12 after release.
        @(negedge clk_i);
        reset_ni = 1'b1;
        rel_cyc  = cyc;
        for (int k = 1; k <= 3; k++) begin
            push(12'h000, 1'b0);
            get_sample("silent");
            check("silent_cycle", 32'(last_cyc), 32'(k * DIV));
        end
        check("silent_overrun", 32'(overrun_o), 32'd0);

        // Step 0x40 from silence: +,-,-,+ (wrap), + (phase back at 0x40).
        fstep_i = 8'h40;
        push(POS, 1'b1); push(NEG, 1'b1); push(NEG, 1'b1); push(POS, 1'b1); push(POS, 1'b1);
        for (int k = 0; k < 5; k++) get_sample("step40");

        // At phase 0x40 switch to 0x80: applied only after the next wrap.
        fstep_i = 8'h80;
        push(NEG, 1'b1); push(NEG, 1'b1); push(POS, 1'b1); push(NEG, 1'b1); push(POS, 1'b1);
        for (int k = 0; k < 5; k++) get_sample("step80");

        // Zero step at phase 0x00 with step 0x80: one more half cycle, then silence.
        fstep_i = 8'h00;
        push(NEG, 1'b1); push(12'h000, 1'b0);
        for (int k = 0; k < 2; k++) get_sample("stop80");

        // Restart at 0x40, then request silence from phase 0x40.
        fstep_i = 8'h40;
        push(POS, 1'b1);
        get_sample("restart");
        fstep_i = 8'h00;
        push(NEG, 1'b1); push(NEG, 1'b1); push(12'h000, 1'b0); push(12'h000, 1'b0);
        for (int k = 0; k < 4; k++) get_sample("stop40");

        // Backpressure: three ticks elapse while ready_i is low.
        fstep_i = 8'h40;
        ready_i = 1'b0;
        for (int i = 2; i <= 13; i++) begin
            @(negedge clk_i);
            if (i == 4) begin
                check("bp_t1_valid",   32'(valid_o),   32'd1);
                check("bp_t1_sample",  32'(sample_o),  32'(POS));
                check("bp_t1_overrun", 32'(overrun_o), 32'd0);
            end
            if (i == 8 || i == 12) begin
                check("bp_hold_valid",   32'(valid_o),   32'd1);
                check("bp_hold_sample",  32'(sample_o),  32'(POS));
                check("bp_hold_overrun", 32'(overrun_o), 32'd1);
            end
        end
        ready_i = 1'b1;
        // Held sample, then phases 0x00 (wrap), 0x40, 0x80.
        push(POS, 1'b1); push(POS, 1'b1); push(POS, 1'b1); push(NEG, 1'b1);
        for (int k = 0; k < 4; k++) get_sample("bp_resume");
        check("bp_overrun_sticky", 32'(overrun_o), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset between clock edges while a sample is pending.
        ready_i = 1'b0;
        repeat (DIV + 1) @(negedge clk_i);
        check("pre_rst_valid",  32'(valid_o),  32'd1);
        check("pre_rst_active", 32'(active_o), 32'd1);
        @(posedge clk_i);
        #3;
        reset_ni = 1'b0;
        #1;
        check("async_sample",  32'(sample_o),  32'd0);
        check("async_valid",   32'(valid_o),   32'd0);
        check("async_active",  32'(active_o),  32'd0);
        check("async_overrun", 32'(overrun_o), 32'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        ready_i  = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
